// File: rtl/counter8_driver.sv
// 3-bit up/down counter feeding the seven-segment decoder; auto (prescaler) or manual (push-button) stepping.
// Optional step debounce filter: define COUNTER8_STEP_DEBOUNCE_EN.
module counter8_driver #(
  parameter int DIV       = 50_000_000,
  parameter int DIV_W     = 26,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEn,
  input  logic       iMode,
  input  logic       iUp,
  input  logic       iStep,
  input  logic       iLoad,
  input  logic [2:0] iLoadVal,
  output logic [2:0] oData,
  output logic       oTick,
  output logic       oCarry
);

  if (DIV < 2 || DB_CYCLES < 1 ||
      (64'(1) << DIV_W) < 64'(DIV)) begin : g_bad_param
    $error("counter8_driver: illegal DIV/DIV_W/DB_CYCLES");
  end

  logic [DIV_W-1:0] presc;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             step_lvl;
  logic             presc_wrap;
  logic             step_edge;
  logic             count_ev;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= iStep;
      sync2 <= sync1;
      prev  <= step_lvl;
    end
  end

`ifdef COUNTER8_STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            filt;

  // Filtered level flips only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge iClk) begin
    if (iRst) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync2 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      filt   <= sync2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign step_lvl = filt;
`else
  assign step_lvl = sync2;
`endif

  assign step_edge  = step_lvl & ~prev;
  assign presc_wrap = !iMode && iEn &&
                      (presc == DIV_W'(DIV - 1));
  assign count_ev   = iMode ? (iEn && step_edge)
                            : presc_wrap;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      presc <= '0;
      oTick <= 1'b0;
    end else if (iLoad || iMode) begin
      presc <= '0;
      oTick <= 1'b0;
    end else if (iEn) begin
      presc <= presc_wrap ? '0 : presc + 1'b1;
      oTick <= presc_wrap;
    end else begin
      oTick <= 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oData  <= 3'd0;
      oCarry <= 1'b0;
    end else if (iLoad) begin
      oData  <= iLoadVal;
      oCarry <= 1'b0;
    end else if (count_ev) begin
      oData  <= iUp ? oData + 3'd1 : oData - 3'd1;
      oCarry <= iUp ? (oData == 3'd7) : (oData == 3'd0);
    end else begin
      oCarry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter8_driver.sv
// Directed bench for counter8_driver with DIV=4, DB_CYCLES=5.
// Debounce checks run only when COUNTER8_STEP_DEBOUNCE_EN is defined.
module tb_counter8_driver;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iEn;
  logic       iMode;
  logic       iUp;
  logic       iStep;
  logic       iLoad;
  logic [2:0] iLoadVal;
  logic [2:0] oData;
  logic       oTick;
  logic       oCarry;

  int total = 0;
  int bad   = 0;

  counter8_driver #(
    .DIV      (4),
    .DIV_W    (3),
    .DB_CYCLES(5)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEn     (iEn),
    .iMode   (iMode),
    .iUp     (iUp),
    .iStep   (iStep),
    .iLoad   (iLoad),
    .iLoadVal(iLoadVal),
    .oData   (oData),
    .oTick   (oTick),
    .oCarry  (oCarry)
  );

  always #5 iClk = ~iClk;

  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] dn_seq [4];
    logic       dn_cy  [4];
    dn_seq = '{3'd1, 3'd0, 3'd7, 3'd6};
    dn_cy  = '{1'b0, 1'b0, 1'b1, 1'b0};

    iRst = 1'b1; iEn = 1'b0; iMode = 1'b0;
    iUp = 1'b1; iStep = 1'b0; iLoad = 1'b0;
    iLoadVal = 3'd0;
    step(2);
    chk("rst_data",  8'(oData),  8'd0);
    chk("rst_tick",  8'(oTick),  8'd0);
    chk("rst_carry", 8'(oCarry), 8'd0);

    // auto count up, 10 steps 0->..->7->0->1->2
    iRst = 1'b0; iEn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("up_tick_lo",  8'(oTick),  8'd0);
      chk("up_carry_lo", 8'(oCarry), 8'd0);
      step(3);
      chk("up_data",  8'(oData),  8'(k % 8));
      chk("up_tick",  8'(oTick),  8'd1);
      chk("up_carry", 8'(oCarry), 8'(k == 8));
    end

    // count down 2->1->0->7->6
    iUp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(4);
      chk("dn_data",  8'(oData),  8'(dn_seq[k]));
      chk("dn_carry", 8'(oCarry), 8'(dn_cy[k]));
    end

    // load coincident with prescaler wrap
    iUp = 1'b1;
    step(3);
    iLoad = 1'b1; iLoadVal = 3'd5;
    step(1);
    chk("ld_data",  8'(oData),  8'd5);
    chk("ld_carry", 8'(oCarry), 8'd0);
    iLoad = 1'b0;
    step(3);
    chk("ld_hold", 8'(oData), 8'd5);
    step(1);
    chk("ld_next", 8'(oData), 8'd6);
    chk("ld_tick", 8'(oTick), 8'd1);

    // enable low freezes count and prescaler
    step(2);
    iEn = 1'b0;
    step(7);
    chk("en_frz",  8'(oData), 8'd6);
    chk("en_tick", 8'(oTick), 8'd0);
    iEn = 1'b1;
    step(1);
    chk("en_re1", 8'(oData), 8'd6);
    step(1);
    chk("en_re2", 8'(oData), 8'd7);

    // manual mode, step held high
    iLoad = 1'b1; iLoadVal = 3'd2; iMode = 1'b1;
    step(1);
    iLoad = 1'b0;
    chk("man_ld", 8'(oData), 8'd2);
    iStep = 1'b1;
    step(1);
    chk("man_e1", 8'(oData), 8'd2);
    step(1);
    chk("man_e2", 8'(oData), 8'd2);
    step(1);
    chk("man_e3", 8'(oData), 8'd3);
    step(7);
    chk("man_hold", 8'(oData), 8'd3);
    chk("man_tick", 8'(oTick), 8'd0);
    iStep = 1'b0;
    step(3);

    // edge while disabled is lost
    iEn = 1'b0; iStep = 1'b1;
    step(4);
    iEn = 1'b1;
    step(3);
    chk("man_lost", 8'(oData), 8'd3);
    iStep = 1'b0;
    step(3);

    // reset mid-count drops prescaler progress
    iMode = 1'b0;
    step(2);
    iRst = 1'b1;
    step(1);
    chk("mid_rst", 8'(oData), 8'd0);
    iRst = 1'b0;
    step(3);
    chk("mid_hold", 8'(oData), 8'd0);
    step(1);
    chk("mid_step", 8'(oData), 8'd1);

`ifdef COUNTER8_STEP_DEBOUNCE_EN
    iMode = 1'b1;
    iStep = 1'b1;
    step(3);
    iStep = 1'b0;
    step(10);
    chk("db_glitch", 8'(oData), 8'd1);
    iStep = 1'b1;
    step(7);
    chk("db_pre", 8'(oData), 8'd1);
    step(1);
    chk("db_step", 8'(oData), 8'd2);
    iStep = 1'b0;
    step(12);
    chk("db_rel", 8'(oData), 8'd2);
    iStep = 1'b1;
    step(4);
    iRst = 1'b1; iStep = 1'b0;
    step(1);
    iRst = 1'b0;
    step(12);
    chk("db_rst", 8'(oData), 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
